// File: rtl/emul_bus_pkg.sv
// Shared types for the emulator output-bus scheduler: bus selector codes,
// requester identities, transaction phases and round-robin helpers.
package emul_bus_pkg;

  typedef enum logic [2:0] {
    SEL_NONE     = 3'd0,
    SEL_CATHODES = 3'd1,
    SEL_ANODES   = 3'd2,
    SEL_KB_WR    = 3'd3,
    SEL_MC_ADDR  = 3'd4,
    SEL_MC_DATA  = 3'd5,
    SEL_KB_RD    = 3'd6,
    SEL_STOP     = 3'd7
  } bus_sel_t;

  typedef enum logic [1:0] {
    REQ_IN12 = 2'd0,
    REQ_KB   = 2'd1,
    REQ_MS   = 2'd2
  } requester_t;

  typedef enum logic [2:0] {
    PH_CLR     = 3'd0,
    PH_CATH    = 3'd1,
    PH_ANODE   = 3'd2,
    PH_KB_WR   = 3'd3,
    PH_KB_RD   = 3'd4,
    PH_MC_ADDR = 3'd5,
    PH_MC_DATA = 3'd6
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_PHASE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_STOP  = 3'd5
  } sched_st_t;

  function automatic requester_t rr_next(input requester_t r);
    case (r)
      REQ_IN12: return REQ_KB;
      REQ_KB:   return REQ_MS;
      default:  return REQ_IN12;
    endcase
  endfunction

  // reqs bit order: [0]=IN12, [1]=KB, [2]=MS; search starts at ptr
  function automatic requester_t rr_pick(input requester_t ptr, input logic [2:0] reqs);
    case (ptr)
      REQ_IN12: return reqs[0] ? REQ_IN12 : (reqs[1] ? REQ_KB : REQ_MS);
      REQ_KB:   return reqs[1] ? REQ_KB : (reqs[2] ? REQ_MS : REQ_IN12);
      default:  return reqs[2] ? REQ_MS : (reqs[0] ? REQ_IN12 : REQ_KB);
    endcase
  endfunction

  function automatic bus_sel_t phase_sel(input phase_t p);
    case (p)
      PH_CATH:    return SEL_CATHODES;
      PH_ANODE:   return SEL_ANODES;
      PH_KB_WR:   return SEL_KB_WR;
      PH_KB_RD:   return SEL_KB_RD;
      PH_MC_ADDR: return SEL_MC_ADDR;
      PH_MC_DATA: return SEL_MC_DATA;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/emul_bus_if.sv
// Requester handshakes plus the selector/strobe bundle of the emulator bus.
interface emul_bus_if;
  import emul_bus_pkg::*;

  logic     in12_req, kb_req, ms_req;
  logic     in12_ack, kb_ack, ms_ack;
  logic     ms6205_ready;
  bus_sel_t state;
  logic     in12_clear_n;
  logic     in12_write_cathode, in12_write_anode;
  logic     keyboard_write, keyboard_read, keyboard_clear;
  logic     ms6205_write_addr_n, ms6205_write_data_n;
  logic     timeout_err;

  modport master (
    input  in12_req, kb_req, ms_req, ms6205_ready,
    output in12_ack, kb_ack, ms_ack, state, in12_clear_n,
           in12_write_cathode, in12_write_anode,
           keyboard_write, keyboard_read, keyboard_clear,
           ms6205_write_addr_n, ms6205_write_data_n, timeout_err
  );

  modport slave (
    output in12_req, kb_req, ms_req, ms6205_ready,
    input  in12_ack, kb_ack, ms_ack, state, in12_clear_n,
           in12_write_cathode, in12_write_anode,
           keyboard_write, keyboard_read, keyboard_clear,
           ms6205_write_addr_n, ms6205_write_data_n, timeout_err
  );
endinterface

// File: rtl/emul_bus_phase_timer.sv
// Times one bus phase: SETUP_W selector-only cycles, STROBE_W strobe cycles,
// then a single hold cycle flagged by phase_done_o.
module emul_bus_phase_timer #(
  parameter int SETUP_W  = 2,
  parameter int STROBE_W = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic strobe_en_o,
  output logic phase_done_o
);

  localparam int LAST = SETUP_W + STROBE_W;
  localparam int CW   = $clog2(LAST + 1);
  localparam logic [CW-1:0] LAST_C       = CW'(LAST);
  localparam logic [CW-1:0] SETUP_C      = CW'(SETUP_W);
  localparam logic [CW-1:0] STROBE_END_C = CW'(LAST - 1);

  logic [CW-1:0] cnt_q;
  logic          active_q;

  // phase cycle counter; a start on the hold cycle chains phases back to back
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= {CW{1'b0}};
      active_q <= 1'b0;
    end else if (start_i) begin
      cnt_q    <= {CW{1'b0}};
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == LAST_C) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign strobe_en_o  = active_q && (cnt_q >= SETUP_C) && (cnt_q <= STROBE_END_C);
  assign phase_done_o = active_q && (cnt_q == LAST_C);

endmodule

// File: rtl/emul_bus_scheduler.sv
// Round-robin time-slot scheduler for the shared emulator output bus: one
// transaction per Enable tick, with registered selector, strobes and acks.
module emul_bus_scheduler #(
  parameter int SETUP_W       = 2,
  parameter int STROBE_W      = 4,
  parameter int READY_TIMEOUT = 1000
) (
  input  logic       Clock_1us,
  input  logic       Rst_n,
  input  logic       Enable,
  input  logic       halt,
  emul_bus_if.master bus
);
  import emul_bus_pkg::*;

  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(READY_TIMEOUT - 1);

  logic          enable_q, pending_q;
  sched_st_t     st_q;
  phase_t        step_q;
  requester_t    rr_q, grant_q;
  logic [TW-1:0] wait_cnt_q;

  logic       rise_s, tick_s, timeout_s, start_s, strobe_en_s, phase_done_s;
  logic [2:0] reqs_s;
  requester_t pick_s;

  bus_sel_t sel_d, sel_q;
  logic clear_n_d, cath_d, anode_d, kbw_d, kbr_d, kbclr_d, addr_n_d, data_n_d;
  logic in12_ack_d, kb_ack_d, ms_ack_d, tmo_d;
  logic clear_n_q, cath_q, anode_q, kbw_q, kbr_q, kbclr_q, addr_n_q, data_n_q;
  logic in12_ack_q, kb_ack_q, ms_ack_q, tmo_q;

  assign rise_s    = Enable & ~enable_q;
  assign tick_s    = rise_s | pending_q;
  assign reqs_s    = {bus.ms_req, bus.kb_req, bus.in12_req};
  assign pick_s    = rr_pick(rr_q, reqs_s);
  assign timeout_s = (st_q == ST_WAIT) && !bus.ms6205_ready && (wait_cnt_q == TMO_LAST);

  emul_bus_phase_timer #(.SETUP_W(SETUP_W), .STROBE_W(STROBE_W)) u_timer (
    .clk_i        (Clock_1us),
    .rst_ni       (Rst_n),
    .start_i      (start_s),
    .strobe_en_o  (strobe_en_s),
    .phase_done_o (phase_done_s)
  );

  // timer start: first phase after grant, ready seen, or chained non-final phase
  always_comb begin
    start_s = 1'b0;
    case (st_q)
      ST_GRANT: start_s = (grant_q != REQ_MS);
      ST_WAIT:  start_s = bus.ms6205_ready;
      ST_PHASE: start_s = phase_done_s &&
                          ((step_q == PH_CLR) || (step_q == PH_CATH) || (step_q == PH_KB_WR));
      default:  start_s = 1'b0;
    endcase
  end

  // transaction FSM, arbiter pointer and 1-deep tick latch
  always_ff @(posedge Clock_1us or negedge Rst_n) begin
    if (!Rst_n) begin
      enable_q   <= 1'b0;
      pending_q  <= 1'b0;
      st_q       <= ST_IDLE;
      step_q     <= PH_CLR;
      rr_q       <= REQ_IN12;
      grant_q    <= REQ_IN12;
      wait_cnt_q <= {TW{1'b0}};
    end else begin
      enable_q <= Enable;
      if (rise_s) pending_q <= 1'b1;
      case (st_q)
        ST_IDLE: begin
          if (halt) begin
            st_q <= ST_STOP;
          end else begin
            // a tick with nothing requesting is dropped
            if (tick_s && (reqs_s != 3'b000)) begin
              grant_q <= pick_s;
              rr_q    <= rr_next(pick_s);
              st_q    <= ST_GRANT;
            end
            pending_q <= 1'b0;
          end
        end
        ST_GRANT: begin
          case (grant_q)
            REQ_IN12: begin step_q <= PH_CLR;   st_q <= ST_PHASE; end
            REQ_KB:   begin step_q <= PH_KB_WR; st_q <= ST_PHASE; end
            default:  begin step_q <= PH_MC_ADDR; st_q <= ST_WAIT; wait_cnt_q <= {TW{1'b0}}; end
          endcase
        end
        ST_WAIT: begin
          if (bus.ms6205_ready) st_q <= ST_PHASE;
          else if (timeout_s)   st_q <= ST_IDLE;
          else                  wait_cnt_q <= wait_cnt_q + TW'(1);
        end
        ST_PHASE: begin
          if (phase_done_s) begin
            case (step_q)
              PH_CLR:     step_q <= PH_CATH;
              PH_CATH:    step_q <= PH_ANODE;
              PH_KB_WR:   step_q <= PH_KB_RD;
              PH_MC_ADDR: begin step_q <= PH_MC_DATA; st_q <= ST_WAIT; wait_cnt_q <= {TW{1'b0}}; end
              default:    st_q <= ST_DONE;
            endcase
          end
        end
        ST_DONE: st_q <= halt ? ST_STOP : ST_IDLE;
        ST_STOP: if (!halt) st_q <= ST_IDLE;
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  // output decode; at most one strobe, only inside a timed phase
  always_comb begin
    sel_d = SEL_NONE; clear_n_d = 1'b1; cath_d = 1'b0; anode_d = 1'b0;
    kbw_d = 1'b0; kbr_d = 1'b0; kbclr_d = 1'b0; addr_n_d = 1'b1; data_n_d = 1'b1;
    in12_ack_d = 1'b0; kb_ack_d = 1'b0; ms_ack_d = 1'b0; tmo_d = 1'b0;
    case (st_q)
      ST_WAIT: begin
        sel_d = phase_sel(step_q);
        tmo_d = timeout_s;
      end
      ST_PHASE: begin
        sel_d = phase_sel(step_q);
        if (strobe_en_s) begin
          case (step_q)
            PH_CLR:     clear_n_d = 1'b0;
            PH_CATH:    cath_d    = 1'b1;
            PH_ANODE:   anode_d   = 1'b1;
            PH_KB_WR:   kbw_d     = 1'b1;
            PH_KB_RD:   kbr_d     = 1'b1;
            PH_MC_ADDR: addr_n_d  = 1'b0;
            PH_MC_DATA: data_n_d  = 1'b0;
            default:    clear_n_d = 1'b1;
          endcase
        end else begin
          clear_n_d = 1'b1;
        end
        kbclr_d    = phase_done_s && (step_q == PH_KB_RD);
        in12_ack_d = phase_done_s && (step_q == PH_ANODE);
        kb_ack_d   = phase_done_s && (step_q == PH_KB_RD);
        ms_ack_d   = phase_done_s && (step_q == PH_MC_DATA);
      end
      ST_STOP: sel_d = SEL_STOP;
      default: sel_d = SEL_NONE;
    endcase
  end

  // output registers
  always_ff @(posedge Clock_1us or negedge Rst_n) begin
    if (!Rst_n) begin
      sel_q <= SEL_NONE; clear_n_q <= 1'b1; cath_q <= 1'b0; anode_q <= 1'b0;
      kbw_q <= 1'b0; kbr_q <= 1'b0; kbclr_q <= 1'b0; addr_n_q <= 1'b1; data_n_q <= 1'b1;
      in12_ack_q <= 1'b0; kb_ack_q <= 1'b0; ms_ack_q <= 1'b0; tmo_q <= 1'b0;
    end else begin
      sel_q <= sel_d; clear_n_q <= clear_n_d; cath_q <= cath_d; anode_q <= anode_d;
      kbw_q <= kbw_d; kbr_q <= kbr_d; kbclr_q <= kbclr_d; addr_n_q <= addr_n_d; data_n_q <= data_n_d;
      in12_ack_q <= in12_ack_d; kb_ack_q <= kb_ack_d; ms_ack_q <= ms_ack_d; tmo_q <= tmo_d;
    end
  end

  assign bus.state               = sel_q;
  assign bus.in12_clear_n        = clear_n_q;
  assign bus.in12_write_cathode  = cath_q;
  assign bus.in12_write_anode    = anode_q;
  assign bus.keyboard_write      = kbw_q;
  assign bus.keyboard_read       = kbr_q;
  assign bus.keyboard_clear      = kbclr_q;
  assign bus.ms6205_write_addr_n = addr_n_q;
  assign bus.ms6205_write_data_n = data_n_q;
  assign bus.in12_ack            = in12_ack_q;
  assign bus.kb_ack              = kb_ack_q;
  assign bus.ms_ack              = ms_ack_q;
  assign bus.timeout_err         = tmo_q;

endmodule
